// File: rtl/f32_pkg.sv
// rtl/f32_pkg.sv - binary32 field layout, constants and operand classification
package f32_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } f32_t;

    localparam int          EXP_BIAS = 127;
    localparam int          EXP_MAX  = 255;
    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam logic [31:0] POS_INF  = 32'h7F800000;
    localparam logic [31:0] NEG_INF  = 32'hFF800000;

    typedef enum logic [2:0] {
        F32_ZERO,
        F32_SUB,
        F32_NORM,
        F32_INF,
        F32_NAN
    } f32_class_e;

    function automatic f32_class_e f32_classify(input f32_t v);
        if (v.exp == 8'(EXP_MAX))
            return (v.frac != 23'd0) ? F32_NAN : F32_INF;
        else if (v.exp == 8'd0)
            return (v.frac != 23'd0) ? F32_SUB : F32_ZERO;
        else
            return F32_NORM;
    endfunction

endpackage

// File: rtl/f32_lzc.sv
// rtl/f32_lzc.sv - 27-bit leading-zero counter, all-zero input yields 27
module f32_lzc (
    input  logic [26:0] data,
    output logic [4:0]  count
);

    // Ascending scan: the highest set bit is the last one to write count.
    always_comb begin
        count = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (data[i])
                count = 5'(26 - i);
        end
    end

endmodule

// File: rtl/f32_adder.sv
// rtl/f32_adder.sv - binary32 RNE adder; F32_ADDER_OUTREG_EN adds an output register stage
module f32_adder
    import f32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c,
    output logic        invalid,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact
);

    f32_t        fa, fb, x, y;
    f32_class_e  ca, cb;
    logic        a_big, eff_sub;
    logic [7:0]  ex, ey, diff, lim;
    logic [23:0] mx, my;
    logic [26:0] lx, ly_ext, ly_sh, ly_al, m;
    logic        sticky_al;
    logic [27:0] sum;
    logic [4:0]  lz, s;
    logic [9:0]  exp_n, exp_r;
    logic        g, rs, up, ovf, res_sign;
    logic [32:0] packed_r;
    logic [31:0] c_n;
    logic        invalid_n, overflow_n, underflow_n, inexact_n;

    assign fa = a;
    assign fb = b;

    f32_lzc u_lzc (
        .data  (sum[26:0]),
        .count (lz)
    );

    always_comb begin
        ca = f32_classify(fa);
        cb = f32_classify(fb);

        // Order by magnitude so the aligned difference is never negative.
        a_big   = (a[30:0] >= b[30:0]);
        x       = a_big ? fa : fb;
        y       = a_big ? fb : fa;
        eff_sub = x.sign ^ y.sign;
        ex      = (x.exp == 8'd0) ? 8'd1 : x.exp;
        ey      = (y.exp == 8'd0) ? 8'd1 : y.exp;
        mx      = {x.exp != 8'd0, x.frac};
        my      = {y.exp != 8'd0, y.frac};
        diff    = ex - ey;

        lx     = {mx, 3'b000};
        ly_ext = {my, 3'b000};
        if (diff >= 8'd27) begin
            ly_sh     = 27'd0;
            sticky_al = |my;
        end else begin
            ly_sh     = ly_ext >> diff[4:0];
            sticky_al = |(ly_ext & ((27'd1 << diff[4:0]) - 27'd1));
        end
        ly_al = {ly_sh[26:1], ly_sh[0] | sticky_al};

        sum = eff_sub ? ({1'b0, lx} - {1'b0, ly_al}) : ({1'b0, lx} + {1'b0, ly_al});

        // Left shift stops where the exponent would drop below the subnormal boundary.
        lim = ex - 8'd1;
        s   = ({3'b000, lz} <= lim) ? lz : lim[4:0];
        if (sum[27]) begin
            m     = {sum[27:2], sum[1] | sum[0]};
            exp_n = {2'b00, ex} + 10'd1;
        end else begin
            m     = sum[26:0] << s;
            exp_n = m[26] ? ({2'b00, ex} - {5'd0, s}) : 10'd0;
        end

        // Rounding carry propagates from fraction into exponent, including subnormal to normal.
        g         = m[2];
        rs        = m[1] | m[0];
        up        = g & (rs | m[3]);
        packed_r  = {exp_n, m[25:3]} + 33'(up);
        exp_r     = packed_r[32:23];
        ovf       = (exp_r >= 10'(EXP_MAX));
        res_sign  = (sum == 28'd0) ? (x.sign & ~eff_sub) : x.sign;

        c_n         = {res_sign, packed_r[30:0]};
        invalid_n   = 1'b0;
        overflow_n  = 1'b0;
        underflow_n = 1'b0;
        inexact_n   = g | rs;

        if (ca == F32_NAN || cb == F32_NAN) begin
            c_n       = QNAN;
            invalid_n = (ca == F32_NAN && !fa.frac[22]) || (cb == F32_NAN && !fb.frac[22]);
            inexact_n = 1'b0;
        end else if (ca == F32_INF && cb == F32_INF && fa.sign != fb.sign) begin
            c_n       = QNAN;
            invalid_n = 1'b1;
            inexact_n = 1'b0;
        end else if (ca == F32_INF || cb == F32_INF) begin
            c_n       = (ca == F32_INF) ? a : b;
            inexact_n = 1'b0;
        end else if (ovf) begin
            c_n        = res_sign ? NEG_INF : POS_INF;
            overflow_n = 1'b1;
            inexact_n  = 1'b1;
        end else begin
            underflow_n = (exp_r == 10'd0) & inexact_n;
        end
    end

`ifdef F32_ADDER_OUTREG_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            c         <= 32'd0;
            invalid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
        end else begin
            c         <= c_n;
            invalid   <= invalid_n;
            overflow  <= overflow_n;
            underflow <= underflow_n;
            inexact   <= inexact_n;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign c         = c_n;
    assign invalid   = invalid_n;
    assign overflow  = overflow_n;
    assign underflow = underflow_n;
    assign inexact   = inexact_n;
`endif

endmodule

// File: tb/tb_f32_adder.sv
// tb/tb_f32_adder.sv - scoreboard bench for f32_adder against an exact wide-integer model
module tb_f32_adder;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [35:0] e;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] c;
    logic        invalid, overflow, underflow, inexact;

    logic  stim_v = 1'b0;
    logic  reg_v  = 1'b0;
    logic  out_v;
    logic  done = 1'b0;
    logic  end_checked = 1'b0;
    int    checks = 0;
    int    errors = 0;
    item_t sb_q[$];

    always #5 clk = ~clk;

    f32_adder dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c         (c),
        .invalid   (invalid),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    always @(posedge clk) reg_v <= stim_v;
`ifdef F32_ADDER_OUTREG_EN
    assign out_v = reg_v;
`else
    assign out_v = stim_v;
`endif

    // Exact sum on a 2^-149 integer grid, then rounded to nearest-even.
    function automatic logic [35:0] ref_add(input logic [31:0] x, input logic [31:0] y);
        logic         xn, yn, xi, yi, sig;
        logic [299:0] vx, vy, mag, q, rem, half, one;
        int           p, sh;
        xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        if (xn || yn)
            return {32'h7FC00000, (xn && !x[22]) || (yn && !y[22]), 3'b000};
        if (xi && yi && x[31] != y[31])
            return {32'h7FC00000, 4'b1000};
        if (xi) return {x, 4'b0000};
        if (yi) return {y, 4'b0000};
        vx = {276'd0, x[30:23] != 8'd0, x[22:0]};
        vy = {276'd0, y[30:23] != 8'd0, y[22:0]};
        if (x[30:23] > 8'd1) vx = vx << (x[30:23] - 8'd1);
        if (y[30:23] > 8'd1) vy = vy << (y[30:23] - 8'd1);
        if (x[31] == y[31]) begin
            mag = vx + vy; sig = x[31];
        end else if (vx >= vy) begin
            mag = vx - vy; sig = x[31];
        end else begin
            mag = vy - vx; sig = y[31];
        end
        if (mag == 300'd0)
            return {x[31] & y[31], 31'd0, 4'b0000};
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p <= 23)
            return {sig, mag[30:0], 4'b0000};
        sh   = p - 23;
        one  = 300'd1;
        q    = mag >> sh;
        rem  = mag & ((one << sh) - one);
        half = one << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + one;
        if (q[24]) begin
            q  = q >> 1;
            sh = sh + 1;
        end
        if (sh + 1 >= 255)
            return {sig, 8'hFF, 23'd0, 4'b0101};
        return {sig, 8'(sh + 1), q[22:0], 3'b000, rem != 300'd0};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] sp [8];
        logic [31:0] r;
        sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
               32'h7FC00001, 32'h7F800001, 32'h7F7FFFFF, 32'h00000001};
        r = $urandom;
        case ($urandom_range(0, 9))
            0:       r = sp[$urandom_range(0, 7)];
            1, 2:    r[30:23] = 8'h00;
            default: if (r[30:23] == 8'hFF) r[30:23] = 8'hFE;
        endcase
        return r;
    endfunction

    // Partner operand with a nearby exponent so cancellation and ties get exercised.
    function automatic logic [31:0] near_op(input logic [31:0] x);
        logic [31:0] r;
        int          ne;
        r  = $urandom;
        ne = int'(x[30:23]) + int'($urandom_range(0, 4)) - 2;
        if (ne < 0)   ne = 0;
        if (ne > 254) ne = 254;
        if ($urandom_range(0, 1) == 1) r[22:0] = x[22:0] ^ (r[22:0] & 23'h7);
        if ($urandom_range(0, 3) == 0) return {~x[31], x[30:0]};
        return {r[31], 8'(ne), r[22:0]};
    endfunction

    task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic rv,
                         input logic [35:0] ev);
        item_t it;
        @(posedge clk);
        #1;
        a      = av;
        b      = bv;
        rst    = rv;
        stim_v = 1'b1;
        it.a = av;
        it.b = bv;
        it.e = ev;
        sb_q.push_back(it);
    endtask

    task automatic drive_reset(input logic [31:0] av, input logic [31:0] bv);
`ifdef F32_ADDER_OUTREG_EN
        drive(av, bv, 1'b0, 36'd0);
`else
        drive(av, bv, 1'b0, ref_add(av, bv));
`endif
    endtask

    always @(negedge clk) begin
        item_t it;
        if (out_v) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL underrun: output presented with got c=%h but no expected entry", c);
            end else begin
                it = sb_q.pop_front();
                if ({c, invalid, overflow, underflow, inexact} !== it.e)
                    begin
                        errors++;
                        $display("FAIL sum a=%h b=%h got c=%h ioux=%b want c=%h ioux=%b",
                                 it.a, it.b, c, {invalid, overflow, underflow, inexact},
                                 it.e[35:4], it.e[3:0]);
                    end
            end
        end
        if (done && !end_checked) begin
            end_checked = 1'b1;
            checks++;
            if (sb_q.size() != 0) begin
                errors++;
                $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
            end
        end
    end

    initial begin
        logic [31:0] ra, rb;
        drive_reset(32'h3F800000, 32'h3F800000);
        drive_reset(32'h7F7FFFFF, 32'h7F7FFFFF);

        drive(32'h3F800000, 32'h3F800000, 1'b1, {32'h40000000, 4'b0000});
        drive(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, {32'h7F800000, 4'b0101});
        drive(32'h7F800000, 32'hFF800000, 1'b1, {32'h7FC00000, 4'b1000});
        drive(32'h3F800000, 32'h33800000, 1'b1, {32'h3F800000, 4'b0001});
        drive(32'h00000001, 32'h00000001, 1'b1, {32'h00000002, 4'b0000});
        drive(32'h3F800000, 32'hBF800000, 1'b1, {32'h00000000, 4'b0000});
        drive(32'h80000000, 32'h80000000, 1'b1, {32'h80000000, 4'b0000});
        drive(32'hFF800000, 32'h3F800000, 1'b1, {32'hFF800000, 4'b0000});
        drive(32'h7F800001, 32'h3F800000, 1'b1, {32'h7FC00000, 4'b1000});
        drive(32'h007FFFFF, 32'h00000001, 1'b1, {32'h00800000, 4'b0000});

        for (int i = 0; i < 3000; i++) begin
            ra = rand_op();
            rb = ($urandom_range(0, 1) == 1) ? near_op(ra) : rand_op();
            if (i == 1500)
                drive_reset(ra, rb);
            else
                drive(ra, rb, 1'b1, ref_add(ra, rb));
        end

        @(posedge clk);
        #1;
        stim_v = 1'b0;
        repeat (3) @(posedge clk);
        done = 1'b1;
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/f32_adder.md
F32_ADDER -- requirements
Module: f32_adder

Interface
REQ-001 The block SHALL have input clk, 1 bit: clock; rising edge is the active edge.
REQ-002 The block SHALL have input rst, 1 bit: reset, synchronous, active-low.
REQ-003 The block SHALL have input a, 32 bits: IEEE-754 binary32 addend A.
REQ-004 The block SHALL have input b, 32 bits: IEEE-754 binary32 addend B.
REQ-005 The block SHALL have output c, 32 bits: binary32 sum a+b.
REQ-006 The block SHALL have output invalid, 1 bit: invalid-operation flag.
REQ-007 The block SHALL have output overflow, 1 bit: overflow flag.
REQ-008 The block SHALL have output underflow, 1 bit: underflow flag.
REQ-009 The block SHALL have output inexact, 1 bit: inexact flag.

Function
REQ-010 The block SHALL compute c = round(a+b) per IEEE-754, using round-to-nearest, ties-to-even only.
REQ-011 Subnormal inputs and outputs SHALL be fully supported; there SHALL be no flush-to-zero.
REQ-012 Alignment SHALL keep guard, round and sticky bits; bits shifted past sticky SHALL be OR-ed into sticky.
REQ-013 Normalization SHALL use a leading-zero count after effective subtraction; the exponent SHALL clamp at the subnormal boundary.
REQ-014 A mantissa carry-out from rounding SHALL increment the exponent.
REQ-015 If either input is NaN, c SHALL be the canonical quiet NaN 0x7FC00000.
REQ-016 invalid SHALL be set when a signaling NaN is input, or for +inf + -inf (c = 0x7FC00000).
REQ-017 inf + finite SHALL return that inf with no flags; inf + inf of the same sign SHALL return that inf.
REQ-018 An exact zero from operands of opposite sign SHALL return +0; (-0)+(-0) SHALL return -0.
REQ-019 On overflow (rounded exponent >= 255), c SHALL be the signed infinity, and overflow and inexact SHALL be set.
REQ-020 inexact SHALL be set whenever the rounded result differs from the exact sum.
REQ-021 underflow SHALL be set when the result is tiny after rounding and inexact; for addition this is never true, so the logic exists but stays 0.
REQ-022 No more than one special-case path SHALL drive c; the priority order SHALL be NaN, inf, normal path.
REQ-023 With F32_ADDER_OUTREG_EN undefined, the datapath SHALL be purely combinational: zero latency, outputs valid within the same cycle.

Reset
REQ-024 With F32_ADDER_OUTREG_EN defined, rst=0 at a rising clk edge SHALL clear c and all four flags to 0.
REQ-025 Without the macro, rst SHALL have no effect, and clk and rst SHALL remain as ports.

Configuration
REQ-026 F32_ADDER_OUTREG_EN defined SHALL register c and the flags on rising clk, giving 1-cycle latency; inputs SHALL remain unregistered.
REQ-027 F32_ADDER_OUTREG_EN undefined SHALL give the combinational behaviour of REQ-023.

Structure
REQ-028 Package f32_pkg SHALL hold:
- a typedef struct {sign, exp[7:0], frac[22:0]};
- constants EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000 and POS_INF/NEG_INF;
- a NaN/inf/zero/subnormal classification function.
REQ-029 A single sub-module f32_lzc (a 27-bit leading-zero counter) SHALL be used for normalization.

Verification
REQ-030 The bench SHALL cover these directed scenarios (flags listed as invalid, overflow, underflow, inexact):
- 0x3F800000 + 0x3F800000 -> c=0x40000000, flags 0000.
- 0x7F7FFFFF + 0x7F7FFFFF -> c=0x7F800000, flags 0101.
- 0x7F800000 + 0xFF800000 -> c=0x7FC00000, flags 1000.
- 0x3F800000 + 0x33800000 (tie) -> c=0x3F800000, flags 0001.
- 0x00000001 + 0x00000001 -> c=0x00000002, flags 0000.
- 0x3F800000 + 0xBF800000 -> c=0x00000000, flags 0000.
REQ-031 The bench SHALL also cover rst=0 with the macro defined -> all outputs 0 on the next edge.
